fc_layer_sequencer: RTL and testbench

- Sequences one fully-connected CNN layer: 16 lanes of 18-bit accumulators, 4 neurons per lane, 64 outputs.
- Fetches the N_IN activations from the upstream buffer and issues them to the layer, one strt per activation at the layer's 5-cycle cadence.
- Waits for the layer's rdy, captures the 4 result groups into a local 64-entry buffer, and streams them downstream over a valid/ready handshake.
- Pulses tx_done to clear the layer for the next image.

---
 rtl/fc_layer_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: issues activations to the layer,
// captures its grouped results and streams them out over valid/ready.
module fc_layer_sequencer #(
    parameter int N_IN      = 100,
    parameter int DW        = 18,
    parameter int LANES     = 16,
    parameter int GROUPS    = 4,
    parameter int ISSUE_GAP = 5,
    parameter int RES_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic                abort,
    output logic                in_rd_en,
    output logic [6:0]          in_addr,
    input  logic [DW-1:0]       in_data,
    output logic                strt,
    output logic [DW-1:0]       din,
    input  logic                rdy,
    input  logic [LANES*DW-1:0] res_data,
    output logic                tx_done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic [5:0]          out_idx,
    output logic                busy,
    output logic                done
);

    localparam int NRES = LANES * GROUPS;
    localparam int IW   = $clog2(NRES);
    localparam int LW   = $clog2(LANES);
    localparam int GW   = $clog2(GROUPS);
    localparam int CW   = 8;

    localparam logic [CW-1:0] GAP_INIT  = CW'(ISSUE_GAP - 2);
    localparam logic [CW-1:0] CAP_FIRST = CW'(RES_LAT - 1);
    localparam logic [CW-1:0] CAP_LAST  = CW'(RES_LAT + GROUPS - 2);
    localparam logic [6:0]    K_LAST    = 7'(N_IN - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NRES - 1);

    typedef enum logic [2:0] {
        IDLE, PRIME, ISSUE, GAP, WAIT_RDY, CAPTURE, DRAIN, DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [6:0]    k;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cap_ofs;
    logic [IW-1:0] idx;
    logic          aborted;
    logic          abort_hit;
    logic          cap_en;
    logic [GW-1:0] grp;
    logic [DW-1:0] din_r;
    logic [DW-1:0] mem [NRES];

    assign abort_hit = abort && (state != IDLE) && (state != DONE);
    assign cap_ofs   = cnt - CAP_FIRST;
    assign grp       = cap_ofs[GW-1:0];
    assign cap_en    = (state == CAPTURE) && ((cnt + CW'(1)) > CAP_FIRST);
    assign din       = din_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state logic; abort overrides every busy state
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     if (go && !abort) nxt = PRIME;
            PRIME:    nxt = ISSUE;
            ISSUE:    nxt = (k == K_LAST) ? WAIT_RDY : GAP;
            GAP:      if (cnt == '0) nxt = ISSUE;
            WAIT_RDY: if (rdy) nxt = CAPTURE;
            CAPTURE:  if (cnt == CAP_LAST) nxt = DRAIN;
            DRAIN:    if (out_ready && idx == IDX_LAST) nxt = DONE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
        if (abort_hit) nxt = DONE;
    end

    // Output decode; strobes are suppressed in an abort cycle
    always_comb begin
        in_rd_en  = 1'b0;
        in_addr   = '0;
        strt      = 1'b0;
        tx_done   = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        busy      = (state != IDLE);
        unique case (state)
            PRIME: in_rd_en = !abort;
            ISSUE: strt = !abort;
            GAP: begin
                if (cnt == '0 && !abort) begin
                    in_rd_en = 1'b1;
                    in_addr  = k + 7'd1;
                end
            end
            DRAIN: begin
                if (!abort) begin
                    out_valid = 1'b1;
                    out_data  = mem[idx];
                    out_idx   = idx;
                end
            end
            DONE: begin
                tx_done = 1'b1;
                done    = !aborted;
            end
            default: ;
        endcase
    end

    // Activation index, cadence/capture counter, drain index, din register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            cnt     <= '0;
            idx     <= '0;
            aborted <= 1'b0;
            din_r   <= '0;
        end else begin
            aborted <= abort_hit;
            unique case (state)
                IDLE: k <= '0;
                ISSUE: begin
                    if (!abort) din_r <= in_data;
                    cnt <= GAP_INIT;
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (!abort) begin
                        k <= k + 7'd1;
                    end
                end
                WAIT_RDY: cnt <= '0;
                CAPTURE: begin
                    cnt <= cnt + CW'(1);
                    idx <= '0;
                end
                DRAIN: if (out_ready && !abort) idx <= idx + IW'(1);
                DONE: k <= '0;
                default: ;
            endcase
        end
    end

    // Result buffer: one group of lanes written per capture cycle
    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int l = 0; l < LANES; l++) begin
                mem[{grp, LW'(l)}] <= res_data[l*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Randomized bench for fc_layer_sequencer with an
// upstream buffer, a layer model and a cycle-level reference.
module tb_fc_layer_sequencer;

    localparam int DW    = 18;
    localparam int LANES = 16;
    localparam int NIN   = 100;
    localparam int NRES  = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                go = 1'b0;
    logic                abort = 1'b0;
    logic                rdy = 1'b0;
    logic                out_ready = 1'b0;
    logic [DW-1:0]       in_data = '0;
    logic [LANES*DW-1:0] res_data = '0;
    logic                in_rd_en;
    logic [6:0]          in_addr;
    logic                strt;
    logic [DW-1:0]       din;
    logic                tx_done;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [5:0]          out_idx;
    logic                busy;
    logic                done;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] upmem   [NIN];
    logic [DW-1:0] res_tab [NRES];

    always #5 clk = ~clk;

    fc_layer_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .abort     (abort),
        .in_rd_en  (in_rd_en),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .strt      (strt),
        .din       (din),
        .rdy       (rdy),
        .res_data  (res_data),
        .tx_done   (tx_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd"}, 32'(in_rd_en), 32'(0));
        check({tag, "_addr"}, 32'(in_addr), 32'(0));
        check({tag, "_strt"}, 32'(strt), 32'(0));
        check({tag, "_din"}, 32'(din), 32'(0));
        check({tag, "_ov"}, 32'(out_valid), 32'(0));
        check({tag, "_odata"}, 32'(out_data), 32'(0));
        check({tag, "_oidx"}, 32'(out_idx), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_txd"}, 32'(tx_done), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
    endtask

    // One image: bp 0=always ready, 1=stall at idx 5 then alternate,
    // 2=random. abort_k>=0 aborts in the gap after activation abort_k.
    // rst_idx>=0 resets while result rst_idx is on the output.
    task automatic run_image(input bit nominal, input int bp,
                             input bit spur, input int abort_k,
                             input int rst_idx);
        int   cyc = 0;
        int   n_strt = 0;
        int   last_strt = -100;
        int   t0 = -1;
        int   n_out = 0;
        int   done_cyc = -1;
        int   bp_cyc = 0;
        int   rdy_dly;
        bit   fin = 1'b0;
        bit   abt = 1'b0;
        bit   rd_q = 1'b0;
        bit   exp_busy;
        bit   exp_ov;
        logic [6:0] addr_q = '0;
        rdy_dly = int'($urandom_range(0, 4));
        for (int i = 0; i < NIN; i++)
            upmem[i] = nominal ? DW'(i + 1) : DW'($urandom);
        for (int n = 0; n < NRES; n++)
            res_tab[n] = nominal ? DW'(100 * (n / LANES) + n % LANES)
                                 : DW'($urandom);
        while (!fin && cyc < 3000) begin
            go = (cyc == 0) ||
                 ((done_cyc < 0 || cyc <= done_cyc) &&
                  $urandom_range(0, 3) == 0);
            abort = (abort_k >= 0) && (n_strt == abort_k + 1) &&
                    (cyc == last_strt + 2);
            if (rd_q) in_data = upmem[addr_q];
            if (t0 < 0 && n_strt == NIN && cyc == last_strt + 1 + rdy_dly)
                t0 = cyc;
            rdy = (spur && n_strt == 51 && cyc > last_strt &&
                   cyc <= last_strt + 3) ||
                  (t0 >= 0 && cyc >= t0);
            for (int l = 0; l < LANES; l++)
                res_data[l*DW +: DW] =
                    (t0 >= 0 && cyc > t0 && cyc <= t0 + 4)
                    ? res_tab[(cyc - t0 - 1) * LANES + l]
                    : DW'($urandom);
            case (bp)
                0:       out_ready = 1'b1;
                1:       out_ready = (n_out < 5) ? 1'b1 :
                                     (bp_cyc < 10) ? 1'b0 : (cyc % 2 == 1);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            #1;
            exp_busy = (cyc >= 1) && (done_cyc < 0 || cyc <= done_cyc);
            exp_ov   = (t0 >= 0) && (cyc >= t0 + 5) && (n_out < NRES);
            if (n_strt > 0)
                check("din", 32'(din), 32'(upmem[n_strt-1]));
            check("busy", 32'(busy), 32'(exp_busy));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("tx_done", 32'(tx_done), 32'(cyc == done_cyc));
            check("done", 32'(done), 32'(cyc == done_cyc && !abt));
            if (abort) begin
                check("abort_strt", 32'(strt), 32'(0));
                check("abort_rd", 32'(in_rd_en), 32'(0));
                abt = 1'b1;
                done_cyc = cyc + 1;
            end
            rd_q   = in_rd_en;
            addr_q = in_addr;
            if (in_rd_en) begin
                check("rd_addr", 32'(in_addr), 32'(n_strt));
                check("rd_cyc", 32'(cyc), 32'(1 + 5 * n_strt));
            end
            if (strt) begin
                check("strt_cyc", 32'(cyc), 32'(2 + 5 * n_strt));
                last_strt = cyc;
                n_strt++;
            end
            if (rst_idx >= 0 && out_valid && n_out == rst_idx) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs("rst_mid");
                fin = 1'b1;
            end else if (out_valid) begin
                check("out_idx", 32'(out_idx), 32'(n_out));
                check("out_data", 32'(out_data), 32'(res_tab[n_out]));
                if (n_out >= 5) bp_cyc++;
                if (out_ready) begin
                    n_out++;
                    if (n_out == NRES) done_cyc = cyc + 1;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("strt_total", 32'(n_strt),
                      32'(abt ? abort_k + 1 : NIN));
                check("out_total", 32'(n_out), 32'(abt ? 0 : NRES));
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) check("timeout", 32'(0), 32'(1));
        go        = 1'b0;
        abort     = 1'b0;
        rdy       = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("idle");
        go    = 1'b1;
        abort = 1'b1;
        #1;
        check("goabort_rd", 32'(in_rd_en), 32'(0));
        @(negedge clk);
        #1;
        check("goabort_busy", 32'(busy), 32'(0));
        go    = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        run_image(1'b1, 0, 1'b0, -1, -1);
        run_image(1'b1, 1, 1'b0, -1, -1);
        run_image(1'b0, 2, 1'b1, -1, -1);
        run_image(1'b0, 0, 1'b0, 40, -1);
        run_image(1'b0, 2, 1'b0, -1, -1);
        run_image(1'b0, 0, 1'b0, -1, 30);
        rst_n = 1'b1;
        @(negedge clk);
        run_image(1'b0, 2, 1'b0, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
